// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host-side write port of the UART transmitter.
// Latency: n/a (bundle of wires); tx_ready and fifo_count come straight from the FIFO count register.
// Backpressure: the master must hold off (or accept the drop) while tx_ready is low.
// Signals: din (word), tx_cmd (write strobe), tx_ready (FIFO not full), fifo_count (words queued).
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 3
);
  logic [DATA_BITS-1:0] din;
  logic                 tx_cmd;
  logic                 tx_ready;
  logic [CNT_W-1:0]     fifo_count;

  // Command/control logic side: drives words, watches space.
  modport master (
    output din,
    output tx_cmd,
    input  tx_ready,
    input  fifo_count
  );

  // Transmitter side.
  modport slave (
    input  din,
    input  tx_cmd,
    output tx_ready,
    output fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART serial transmitter with internal baud divider and small TX FIFO.
// Latency: a word accepted at edge N into an idle, empty block drives the start bit after edge N+1.
// Backpressure: bus.tx_ready falls when the FIFO is full; tx_cmd is then ignored and the word dropped.
// Ports: sys_clk; reset (synchronous, active-high); bus (slave: din, tx_cmd, tx_ready, fifo_count);
//        txd (registered serial line, idles high); tx_busy (high whenever a frame is on the line).
// Optional: define UART_TX_PARITY_EN to add a parity bit after the data (PARITY_ODD selects odd).

// uart_tx_fifo_buf: generic synchronous FIFO used as the TX queue.
// Latency: written word is visible on rd_dat/rd_vld the cycle after the push.
// Backpressure: wr_rdy = not full (registered count only, a same-cycle pop does not free a slot).
module uart_tx_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic [CNT_W-1:0] count
);
  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  assign wr_rdy = (count_q != FULL);
  assign rd_vld = (count_q != '0);
  assign rd_dat = mem_q[rd_ptr_q];
  assign count  = count_q;
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_vld && rd_rdy;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Push and pop together leave the count unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = 434,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
`ifdef UART_TX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic          sys_clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus,
  output logic          txd,
  output logic          tx_busy
);
  localparam int                BAUD_W    = $clog2(CLK_DIV);
  localparam int                BIT_W     = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic              PAR_INV   = (PARITY_ODD != 0);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic                   fifo_vld;
  logic                   fifo_pop;
  logic [DATA_BITS-1:0]   fifo_dat;
  logic                   baud_last;
  logic                   load;

  uart_tx_fifo_buf #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk    (sys_clk),
    .rst    (reset),
    .wr_vld (bus.tx_cmd),
    .wr_rdy (bus.tx_ready),
    .wr_dat (bus.din),
    .rd_vld (fifo_vld),
    .rd_rdy (fifo_pop),
    .rd_dat (fifo_dat),
    .count  (bus.fifo_count)
  );

  assign baud_last = (baud_q == BAUD_LAST);
  assign txd       = txd_q;
  assign tx_busy   = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    fifo_pop = 1'b0;
    load     = 1'b0;

    // Every non-idle state advances the divider; bit boundaries reset it below.
    if (state_q != ST_IDLE) begin
      baud_d = baud_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        load   = fifo_vld;
      end

      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            txd_d   = parity_q;
            state_d = ST_PARITY;
`else
            txd_d   = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          txd_d   = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // A queued word starts on the very next cycle: no idle gap between frames.
            if (fifo_vld) begin
              load = 1'b1;
            end else begin
              txd_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      default: begin
        txd_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    // Frame start: pop the head, latch it (and its parity) so later din changes cannot
    // reach the frame, drive the start bit and restart the divider for exact bit timing.
    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_dat;
`ifdef UART_TX_PARITY_EN
      parity_d = (^fifo_dat) ^ PAR_INV;
`endif
      txd_d    = 1'b0;
      baud_d   = '0;
      bit_d    = '0;
      state_d  = ST_START;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: drives three transmitter configurations side by side and checks every
// line cycle against a per-configuration scoreboard of expected (txd, busy) values.
// Configs: 0 = 8N1, 1 = 8 data / 2 stop (odd parity when enabled), 2 = 5N1; all CLK_DIV=4, depth 4.
module tb_uart_tx_fifo;
  localparam int NDUT  = 3;
  localparam int CLKD  = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int DB [NDUT] = '{8, 8, 5};
  localparam int SB [NDUT] = '{1, 2, 1};
  localparam int PO [NDUT] = '{0, 1, 0};
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // One expected line cycle; start marks the first cycle of a frame (the FIFO pop).
  typedef struct packed {
    logic txd;
    logic busy;
    logic start;
  } ent_t;

  logic                      sys_clk;
  logic                      reset;
  logic [NDUT-1:0]           cmd;
  logic [NDUT-1:0][8:0]      din;
  logic [NDUT-1:0]           txd_w;
  logic [NDUT-1:0]           busy_w;
  logic [NDUT-1:0]           rdy_w;
  logic [NDUT-1:0][CW-1:0]   cnt_w;

  ent_t line_q [NDUT][$];
  int   mdl_cnt [NDUT];
  int   n_assert;
  int   n_fail;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  uart_tx_fifo_if #(.DATA_BITS(8), .CNT_W(CW)) if0 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .CNT_W(CW)) if1 ();
  uart_tx_fifo_if #(.DATA_BITS(5), .CNT_W(CW)) if2 ();

  assign if0.din    = din[0][7:0];
  assign if1.din    = din[1][7:0];
  assign if2.din    = din[2][4:0];
  assign if0.tx_cmd = cmd[0];
  assign if1.tx_cmd = cmd[1];
  assign if2.tx_cmd = cmd[2];
  assign rdy_w[0]   = if0.tx_ready;
  assign rdy_w[1]   = if1.tx_ready;
  assign rdy_w[2]   = if2.tx_ready;
  assign cnt_w[0]   = if0.fifo_count;
  assign cnt_w[1]   = if1.fifo_count;
  assign cnt_w[2]   = if2.fifo_count;

  uart_tx_fifo #(
    .DATA_BITS(8), .CLK_DIV(CLKD), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
`ifdef UART_TX_PARITY_EN
    , .PARITY_ODD(0)
`endif
  ) u_dut0 (
    .sys_clk(sys_clk), .reset(reset), .bus(if0), .txd(txd_w[0]), .tx_busy(busy_w[0])
  );

  uart_tx_fifo #(
    .DATA_BITS(8), .CLK_DIV(CLKD), .STOP_BITS(2), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
`ifdef UART_TX_PARITY_EN
    , .PARITY_ODD(1)
`endif
  ) u_dut1 (
    .sys_clk(sys_clk), .reset(reset), .bus(if1), .txd(txd_w[1]), .tx_busy(busy_w[1])
  );

  uart_tx_fifo #(
    .DATA_BITS(5), .CLK_DIV(CLKD), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
`ifdef UART_TX_PARITY_EN
    , .PARITY_ODD(0)
`endif
  ) u_dut2 (
    .sys_clk(sys_clk), .reset(reset), .bus(if2), .txd(txd_w[2]), .tx_busy(busy_w[2])
  );

  task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %0h expected %0h at %0t", tag, d, obs, exp, $time);
    end
  endtask

  // Expected line for one word: start, data LSB first, optional parity, stop bits.
  function automatic void push_frame(input int d, input logic [8:0] w);
    ent_t e;
    logic p;
    p = (PO[d] != 0);
    for (int c = 0; c < CLKD; c++) begin
      e = '{txd: 1'b0, busy: 1'b1, start: (c == 0)};
      line_q[d].push_back(e);
    end
    for (int i = 0; i < DB[d]; i++) begin
      p = p ^ w[i];
      for (int c = 0; c < CLKD; c++) begin
        e = '{txd: w[i], busy: 1'b1, start: 1'b0};
        line_q[d].push_back(e);
      end
    end
    if (PAR_EN) begin
      for (int c = 0; c < CLKD; c++) begin
        e = '{txd: p, busy: 1'b1, start: 1'b0};
        line_q[d].push_back(e);
      end
    end
    for (int c = 0; c < SB[d] * CLKD; c++) begin
      e = '{txd: 1'b1, busy: 1'b1, start: 1'b0};
      line_q[d].push_back(e);
    end
  endfunction

  // One clock: note which words get accepted at this edge, then compare the cycle after it.
  task automatic step();
    logic [NDUT-1:0] acc;
    ent_t            e;
    for (int d = 0; d < NDUT; d++) begin
      acc[d] = !reset && cmd[d] && (mdl_cnt[d] != DEPTH);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    for (int d = 0; d < NDUT; d++) begin
      e = '{txd: 1'b1, busy: 1'b0, start: 1'b0};
      if (reset) begin
        line_q[d].delete();
        mdl_cnt[d] = 0;
      end else if (line_q[d].size() != 0) begin
        e = line_q[d].pop_front();
      end
      if (e.start) mdl_cnt[d]--;
      if (acc[d]) begin
        mdl_cnt[d]++;
        push_frame(d, din[d]);
      end
      chk("txd",        d, 8'(txd_w[d]),  8'(e.txd));
      chk("tx_busy",    d, 8'(busy_w[d]), 8'(e.busy));
      chk("fifo_count", d, 8'(cnt_w[d]),  8'(mdl_cnt[d]));
      chk("tx_ready",   d, 8'(rdy_w[d]),  8'(mdl_cnt[d] != DEPTH));
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    cmd      = '0;
    din      = '0;
    for (int d = 0; d < NDUT; d++) mdl_cnt[d] = 0;

    // Reset state.
    step();
    step();
    reset = 1'b0;
    repeat (3) step();

    // Single frames: 0x65 on 8N1, 0x00 then 0xA5 on two-stop, 0x15 on 5-bit (upper din bits set).
    din[0] = 9'h065;
    din[1] = 9'h000;
    din[2] = 9'h1F5;
    cmd    = 3'b111;
    step();
    // Scribble on din of already-accepted words; only config 1 writes its second word.
    din[0] = 9'h1FF;
    din[1] = 9'h0A5;
    din[2] = 9'h00A;
    cmd    = 3'b010;
    step();
    cmd    = '0;
    din[1] = 9'h1FF;
    repeat (110) step();

    // Six back-to-back writes into depth 4: five accepted, the sixth dropped.
    for (int k = 0; k < 6; k++) begin
      din[0] = {1'b0, 8'hA1 + 8'(k * 17)};
      cmd    = 3'b001;
      step();
    end
    cmd = '0;
    repeat (240) step();

    // Reset during data bit 3 with two words still queued: abort and flush.
    for (int k = 0; k < 3; k++) begin
      din[0] = {1'b0, 8'h3C + 8'(k * 45)};
      cmd    = 3'b001;
      step();
    end
    cmd = '0;
    repeat (15) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (60) step();

    for (int d = 0; d < NDUT; d++) begin
      chk("drained", d, 8'(line_q[d].size()), 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
